// File: rtl/apb4_rr_arbiter.sv
// apb4_rr_arbiter: round-robin sharing of one APB4 master port between NUM_REQ requesters
module apb4_rr_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 255
) (
  input  logic                                 pclk,
  input  logic                                 presetn,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ-1:0]                   req_write_i,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]    req_wdata_i,
  input  logic [NUM_REQ*APB_DATA_WIDTH/8-1:0]  req_strb_i,
  input  logic [NUM_REQ*3-1:0]                 req_prot_i,
  output logic [NUM_REQ-1:0]                   rsp_valid_o,
  output logic [APB_DATA_WIDTH-1:0]            rsp_rdata_o,
  output logic                                 rsp_slverr_o,
  output logic [APB_ADDR_WIDTH-1:0]            paddr,
  output logic [2:0]                           pprot,
  output logic                                 psel,
  output logic                                 penable,
  output logic                                 pwrite,
  output logic [APB_DATA_WIDTH-1:0]            pwdata,
  output logic [APB_DATA_WIDTH/8-1:0]          pstrb,
  input  logic                                 pready,
  input  logic [APB_DATA_WIDTH-1:0]            prdata,
  input  logic                                 pslverr
);
  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t        state, state_n;
  logic [PW-1:0] rr_ptr, gnt, gnt_q;
  logic [PW:0]   idx;
  logic [CW-1:0] wait_cnt;
  logic          accept, done, tmo;
  always_comb begin
    gnt = rr_ptr;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      idx = idx >= (PW+1)'(NUM_REQ) ? idx - (PW+1)'(NUM_REQ) : idx;
      if (req_valid_i[idx[PW-1:0]]) gnt = idx[PW-1:0];
    end
  end
  assign accept      = state == IDLE && |req_valid_i;
  assign done        = state == ACCESS && pready;
  assign tmo         = state == ACCESS && !pready && TIMEOUT != 0 && wait_cnt == CW'(TIMEOUT);
  assign req_ready_o = accept ? NUM_REQ'(1) << gnt : '0;
  assign psel        = state != IDLE;
  assign penable     = state == ACCESS;
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (accept) state_n = SETUP;
    else if (state == SETUP) state_n = ACCESS;
    else if (done || tmo) state_n = IDLE;
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      gnt_q        <= '0;
      rr_ptr       <= '0;
      wait_cnt     <= '0;
      paddr        <= '0;
      pprot        <= '0;
      pwrite       <= 1'b0;
      pwdata       <= '0;
      pstrb        <= '0;
      rsp_valid_o  <= '0;
      rsp_rdata_o  <= '0;
      rsp_slverr_o <= 1'b0;
    end else begin
      if (accept) begin
        gnt_q  <= gnt;
        paddr  <= req_addr_i[gnt*AW +: AW];
        pprot  <= req_prot_i[gnt*3 +: 3];
        pwrite <= req_write_i[gnt];
        pwdata <= req_write_i[gnt] ? req_wdata_i[gnt*DW +: DW] : '0;
        pstrb  <= req_write_i[gnt] ? req_strb_i[gnt*SW +: SW] : '0;
      end
      wait_cnt    <= state == SETUP ? '0 : (state == ACCESS && !pready && TIMEOUT != 0) ? wait_cnt + CW'(1) : wait_cnt;
      rsp_valid_o <= (done || tmo) ? NUM_REQ'(1) << gnt_q : '0;
      if (done || tmo) begin
        rsp_rdata_o  <= (done && !pwrite) ? prdata : '0;
        rsp_slverr_o <= done ? pslverr : 1'b1;
        rr_ptr       <= gnt_q == PW'(NUM_REQ - 1) ? '0 : gnt_q + PW'(1);
      end
    end
  end
endmodule

// File: doc/apb4_rr_arbiter.md
# apb4_rr_arbiter

Round-robin arbiter that shares one APB4 master port between `NUM_REQ` requesters (e.g. a debug module, a DMA engine and a boot loader all reaching one peripheral bus). Each requester issues single transfers on a valid/ready request channel and receives a one-cycle response pulse. The block sequences the APB4 SETUP/ACCESS phases and enforces a configurable PREADY timeout. It sits directly in front of the `apb4_if` master modport.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, legal range 2..8.
- `APB_ADDR_WIDTH`, 32: PADDR width.
- `APB_DATA_WIDTH`, 32: PWDATA/PRDATA width; PSTRB width is `APB_DATA_WIDTH/8`.
- `TIMEOUT`, 255: maximum number of ACCESS cycles without PREADY; 0 disables the timeout.

Ports (AW = `APB_ADDR_WIDTH`, DW = `APB_DATA_WIDTH`, SW = DW/8; requester i occupies slice i of each flattened vector):
- `pclk` in 1: clock.
- `presetn` in 1: asynchronous active-low reset.
- `req_valid_i` in NUM_REQ: request pending, one bit per requester.
- `req_ready_o` out NUM_REQ: request accepted this cycle; one-hot or zero.
- `req_addr_i` in NUM_REQ*AW: transfer address.
- `req_write_i` in NUM_REQ: 1 = write, 0 = read.
- `req_wdata_i` in NUM_REQ*DW: write data.
- `req_strb_i` in NUM_REQ*SW: write strobes.
- `req_prot_i` in NUM_REQ*3: PPROT value.
- `rsp_valid_o` out NUM_REQ: one-cycle completion pulse; one-hot or zero.
- `rsp_rdata_o` out DW: read data, valid with `rsp_valid_o`; shared by all requesters.
- `rsp_slverr_o` out 1: error flag, valid with `rsp_valid_o`.
- `paddr`, `pprot`, `psel`, `penable`, `pwrite`, `pwdata`, `pstrb` out, widths AW/3/1/1/1/DW/SW: APB4 master outputs.
- `pready`, `prdata`, `pslverr` in, widths 1/DW/1: APB4 master inputs.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any `req_valid_i` bit is set, grant g is the first set bit found searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - `req_ready_o[g]` is driven combinationally in the same cycle.
  - g and that requester's addr/write/wdata/strb/prot are latched; next state is SETUP.
- SETUP: `psel`=1, `penable`=0, APB outputs driven from the latched fields. Next state is ACCESS unconditionally.
- ACCESS: `psel`=1, `penable`=1.
  - On `pready`=1: capture `prdata` (reads only; writes return 0) and `pslverr`, pulse `rsp_valid_o[g]` in the next cycle, set `rr_ptr` = (g+1) mod NUM_REQ, go to IDLE.
  - Timeout: a wait counter counts ACCESS cycles with `pready`=0. When it reaches TIMEOUT (TIMEOUT≠0), the transfer ends: `psel`/`penable` drop, the response is `rsp_slverr_o`=1 and `rsp_rdata_o`=0, and `rr_ptr` advances as on normal completion. The counter clears on entry to SETUP.
- The latched fields stay constant from SETUP through the end of ACCESS, independent of requester inputs.
- Requesters hold their fields stable while valid and not yet ready. After the handshake they may change the fields freely.
- A requester may deassert valid before ready without error; it is simply not granted.
- `pwdata`/`pstrb` are driven to 0 on reads. `paddr` and the other outputs hold their last values in IDLE; `psel`=0 there.

## Timing
- Reset: `psel`, `penable`, `pwrite` = 0; `paddr`, `pwdata`, `pstrb`, `pprot` = 0; `req_ready_o`, `rsp_valid_o` = 0; `rsp_rdata_o`, `rsp_slverr_o` = 0; `rr_ptr` = 0; state IDLE.
- Zero-wait transfer:
  - Handshake at cycle t.
  - SETUP at t+1.
  - ACCESS at t+2, with `pready` high.
  - `rsp_valid_o` pulses at t+3; the FSM is in IDLE at t+3 and can accept a new request in that same cycle.
- Minimum period is 3 cycles per transfer.
- Each wait state adds 1 cycle.
- Timeout: with TIMEOUT=N, ACCESS lasts N+1 cycles, and the response follows 1 cycle after the last ACCESS cycle.
- Simultaneous requests: exactly one `req_ready_o` bit is asserted. No request is accepted outside IDLE, and none in the cycle that completes a transfer.
- Fairness: a continuously requesting master is granted within NUM_REQ transfers.
- Reset mid-transfer: all outputs go to their reset values immediately (asynchronously), and no response is issued for the aborted transfer.
- `pready` sampled in SETUP is ignored.

## Test plan
- Single read, NUM_REQ=2: req0 reads 0x1000 and the slave returns 0xDEADBEEF with zero wait → `psel` rises at t+1, `penable` at t+2, `rsp_valid_o`=2'b01 at t+3 with `rsp_rdata_o`=0xDEADBEEF and `rsp_slverr_o`=0.
- Round-robin: all 4 requesters (NUM_REQ=4) valid continuously → grant order 0,1,2,3,0; each grant is one-hot and consecutive grants are 3 cycles apart.
- Wait states and error: write with 3 cycles of `pready`=0, then `pready`=1 with `pslverr`=1 → ACCESS lasts 4 cycles and the response has `rsp_slverr_o`=1; `paddr`/`pwdata`/`pstrb` are stable throughout.
- Timeout: TIMEOUT=4 and `pready` held 0 → ACCESS lasts 5 cycles, `psel` drops, and the response has `rsp_slverr_o`=1 and `rsp_rdata_o`=0. The next request is then served normally.
- Reset mid-ACCESS: assert `presetn`=0 while `penable`=1 → `psel`=`penable`=0 in the same cycle, no `rsp_valid_o`, and `rr_ptr`=0, so a subsequent req1+req0 grants req0 first.
- Input change after accept: req1 changes `req_addr_i` from 0x20 to 0x40 one cycle after ready → `paddr` stays 0x20 for SETUP and ACCESS.
